dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have `clk` (input, 1): the single clock; all state changes on its rising edge.
REQ-002 SHALL have `rst` (input, 1): synchronous, active-high reset.
REQ-003 SHALL have `mem_req` (input, 1): core issues LW/SW; held stable with addr/data until `hit`.
REQ-004 SHALL have `mem_write_en` (input, 1): 1 = SW, 0 = LW; valid only while `mem_req` = 1.
REQ-005 SHALL have `mem_addr` (input, 32): byte address; bits [1:0] ignored.
REQ-006 SHALL have `mem_wdata` (input, 32): SW store data.
REQ-007 SHALL have `mem_rdata` (output, 32): LW load data; valid while `hit` = 1.
REQ-008 SHALL have `hit` (output, 1): request completes this cycle; feeds core `pc_we`.
REQ-009 SHALL have `mm_req` (output, 1): main-memory word request.
REQ-010 SHALL have `mm_we` (output, 1): 1 = main-memory write.
REQ-011 SHALL have `mm_addr` (output, 32): word-aligned main-memory address.
REQ-012 SHALL have `mm_wdata` (output, 32): write-back word.
REQ-013 SHALL have `mm_rdata` (input, 32): refill word; valid with `mm_ack`.
REQ-014 SHALL have `mm_ack` (input, 1): one-cycle pulse per completed word.
REQ-015 SHALL have `hit_count` and `miss_count` (outputs, 32 each): statistics counters (see Configuration).

Function
REQ-016 SHALL be direct-mapped, write-back, write-allocate: 64 sets, 4-word blocks; tag = addr[31:10], index = addr[9:4], word = addr[3:2].
REQ-017 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-018 In IDLE with `mem_req` = 1, SHALL compare tags combinationally; on valid and matching tag, `hit` = 1 the same cycle (zero-stall hit).
REQ-019 On a read hit, `mem_rdata` SHALL be the addressed word, combinationally.
REQ-020 On a write hit, the word SHALL be written and dirty set at the clock edge ending the hit cycle.
REQ-021 On a miss, `hit` SHALL be 0; next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-022 WRITEBACK SHALL write 4 words, victim tag/index, word 0..3, with `mm_req` = `mm_we` = 1; on the 4th `mm_ack` go to ALLOCATE.
REQ-023 ALLOCATE SHALL read 4 words, request tag/index, word 0..3, with `mm_req` = 1 and `mm_we` = 0.
REQ-024 In ALLOCATE, SHALL capture each `mm_rdata` on `mm_ack`; on the 4th ack set valid, clear dirty, write the tag and return to IDLE.
REQ-025 After refill, the held request SHALL hit in IDLE; miss latency = memory time + 1 cycle.
REQ-026 A 2-bit word counter SHALL advance only on `mm_ack`, wrap 3 -> 0 at phase end, and hold `mm_addr`/`mm_wdata` stable between acks.
REQ-027 `mm_req` SHALL be 0 in IDLE; `hit` SHALL be 0 outside IDLE.
REQ-028 `mm_ack` received in IDLE SHALL be ignored.
REQ-029 `mem_req` deasserted in IDLE SHALL produce no state change.

Reset
REQ-030 On `rst`: state = IDLE, all 64 valid and dirty bits = 0, word counter = 0, `mm_req` = 0, `hit` = 0, counters = 0.
REQ-031 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abandon the burst: `mm_req` = 0 the next cycle and partial data discarded.
REQ-032 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-033 With `DCACHE_STATS_EN` defined: `hit_count` +1 each cycle `hit` = 1; `miss_count` +1 on each IDLE->WRITEBACK/ALLOCATE transition; both wrap at 2^32.
REQ-034 Without `DCACHE_STATS_EN`: `hit_count` and `miss_count` SHALL be constant 0 and no counter flops exist.

Structure
REQ-035 Package `dcache_pkg` SHALL hold TAG_W=22, INDEX_W=6, WORD_W=2, NUM_SETS=64, WORDS_PER_BLOCK=4, and the FSM state enum.
REQ-036 Storage (tag, valid, dirty, data) SHALL live in sub-module `dcache_array`; the FSM and memory interface live in `dcache_controller`.

Verification
REQ-037 After reset, LW 0x0000_0040, memory acks each word after 3 cycles -> 4 reads at 0x40/0x44/0x48/0x4C, then `hit` = 1 with the word at 0x40; `miss_count` = 1.
REQ-038 Repeat LW 0x0000_0044 -> `hit` = 1 the same cycle, no `mm_req`; `hit_count` increments.
REQ-039 SW 0xDEAD_BEEF to 0x44 (hit), then LW 0x0000_0444 (same index) -> write-back of 4 words at 0x40-0x4C with 0xDEAD_BEEF at 0x44, then refill from 0x440.
REQ-040 Assert `rst` after the 2nd `mm_ack` of a refill -> `mm_req` = 0 next cycle; a later LW 0x40 misses again.
REQ-041 SW 0x1234_5678 to 0x0000_0800 (miss, clean victim) -> ALLOCATE only; the block becomes dirty and a later eviction writes 0x1234_5678 back.
REQ-042 Build without `DCACHE_STATS_EN` -> counters read 0 after the REQ-037 to REQ-039 traffic.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, types and helpers for the direct-mapped data cache.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int TAG_W           = 22;
  localparam int INDEX_W         = 6;
  localparam int WORD_W          = 2;
  localparam int NUM_SETS        = 64;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] block_t;

  // Builds the word-aligned main-memory address of one word of a block.
  function automatic logic [ADDR_W-1:0] blockAddr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] index,
                                                  input logic [WORD_W-1:0]  word);
    return {tag, index, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: bundles the core-side request port and the main-memory word port.
// The cache itself connects through the slave modport; the environment (core
// plus memory) drives through the master modport.
interface dcache_if;
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  word_t             mem_rdata;
  logic              hit;

  logic              mm_req;
  logic              mm_we;
  logic [ADDR_W-1:0] mm_addr;
  word_t             mm_wdata;
  word_t             mm_rdata;
  logic              mm_ack;

  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  mem_req, mem_write_en, mem_addr, mem_wdata, mm_rdata, mm_ack,
    output mem_rdata, hit, mm_req, mm_we, mm_addr, mm_wdata, hit_count, miss_count
  );

  modport master (
    output mem_req, mem_write_en, mem_addr, mem_wdata, mm_rdata, mm_ack,
    input  mem_rdata, hit, mm_req, mm_we, mm_addr, mm_wdata, hit_count, miss_count
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: tag, valid, dirty and data storage for the data cache.
// Only valid/dirty are reset; tag and data contents are don't-care until a
// refill marks the set valid.
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output block_t             block_o,
  input  logic               wordWe_i,
  input  logic [WORD_W-1:0]  wordSel_i,
  input  word_t              wordData_i,
  input  logic               markDirty_i,
  input  logic               fillDone_i,
  input  logic [TAG_W-1:0]   fillTag_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tagMem_q  [NUM_SETS];
  word_t               dataMem_q [NUM_SETS][WORDS_PER_BLOCK];

  // Line state: a completed refill makes a set valid and clean, a store hit dirties it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fillDone_i) begin
        valid_q[index_i] <= 1'b1;
        dirty_q[index_i] <= 1'b0;
      end
      if (markDirty_i) begin
        dirty_q[index_i] <= 1'b1;
      end
    end
  end

  // Tag and data storage, written by refill words, the final refill ack and store hits.
  always_ff @(posedge clk_i) begin
    if (wordWe_i) begin
      dataMem_q[index_i][wordSel_i] <= wordData_i;
    end
    if (fillDone_i) begin
      tagMem_q[index_i] <= fillTag_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tagMem_q[index_i];

  // Whole addressed block is visible so hits and write-backs can pick any word.
  always_comb begin
    block_o = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      block_o[w] = dataMem_q[index_i][w];
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// (64 sets x 4 words). Hits complete combinationally in IDLE; misses run an
// optional 4-word WRITEBACK burst followed by a 4-word ALLOCATE burst.
// Define DCACHE_STATS_EN to build the hit/miss statistics counters.
module dcache_controller
  import dcache_pkg::*;
(
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);

  state_e            state_q;
  logic [WORD_W-1:0] wordCnt_q;
  logic [WORD_W-1:0] wordCnt_d;
  logic              mmReq_q;
  logic              mmWe_q;
  logic [ADDR_W-1:0] mmAddr_q;
  word_t             mmWdata_q;

  logic [TAG_W-1:0]   reqTag;
  logic [INDEX_W-1:0] reqIndex;
  logic [WORD_W-1:0]  reqWord;

  logic               lineValid;
  logic               lineDirty;
  logic [TAG_W-1:0]   lineTag;
  block_t             lineData;

  logic               hitNow;
  logic               missStart;
  logic               lastWord;
  logic               refillAck;

  logic               arrWordWe;
  logic [WORD_W-1:0]  arrWordSel;
  word_t              arrWordData;
  logic               arrMarkDirty;
  logic               arrFillDone;

  assign reqTag   = bus.mem_addr[31:10];
  assign reqIndex = bus.mem_addr[9:4];
  assign reqWord  = bus.mem_addr[3:2];

  assign hitNow    = (state_q == IDLE) && bus.mem_req && lineValid && (lineTag == reqTag);
  assign missStart = (state_q == IDLE) && bus.mem_req && !hitNow;
  assign lastWord  = (wordCnt_q == '1);
  assign wordCnt_d = wordCnt_q + 1'b1;
  assign refillAck = (state_q == ALLOCATE) && bus.mm_ack;

  // Array write controls: refill words come from memory, store hits from the core.
  always_comb begin
    arrWordWe    = !rst && ((hitNow && bus.mem_write_en) || refillAck);
    arrWordSel   = reqWord;
    arrWordData  = bus.mem_wdata;
    arrMarkDirty = !rst && hitNow && bus.mem_write_en;
    arrFillDone  = !rst && refillAck && lastWord;
    if (state_q == ALLOCATE) begin
      arrWordSel  = wordCnt_q;
      arrWordData = bus.mm_rdata;
    end
  end

  dcache_array u_array (
    .clk_i       (clk),
    .rst_i       (rst),
    .index_i     (reqIndex),
    .valid_o     (lineValid),
    .dirty_o     (lineDirty),
    .tag_o       (lineTag),
    .block_o     (lineData),
    .wordWe_i    (arrWordWe),
    .wordSel_i   (arrWordSel),
    .wordData_i  (arrWordData),
    .markDirty_i (arrMarkDirty),
    .fillDone_i  (arrFillDone),
    .fillTag_i   (reqTag)
  );

  // Miss FSM with registered memory-port outputs; the word counter moves only on mm_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      mmReq_q   <= 1'b0;
      mmWe_q    <= 1'b0;
      mmAddr_q  <= '0;
      mmWdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (missStart) begin
            wordCnt_q <= '0;
            mmReq_q   <= 1'b1;
            if (lineValid && lineDirty) begin
              state_q   <= WRITEBACK;
              mmWe_q    <= 1'b1;
              mmAddr_q  <= blockAddr(lineTag, reqIndex, '0);
              mmWdata_q <= lineData[0];
            end else begin
              state_q  <= ALLOCATE;
              mmWe_q   <= 1'b0;
              mmAddr_q <= blockAddr(reqTag, reqIndex, '0);
            end
          end
        end
        WRITEBACK: begin
          if (bus.mm_ack) begin
            wordCnt_q <= wordCnt_d;
            if (lastWord) begin
              state_q  <= ALLOCATE;
              mmWe_q   <= 1'b0;
              mmAddr_q <= blockAddr(reqTag, reqIndex, '0);
            end else begin
              mmAddr_q  <= blockAddr(lineTag, reqIndex, wordCnt_d);
              mmWdata_q <= lineData[wordCnt_d];
            end
          end
        end
        ALLOCATE: begin
          if (bus.mm_ack) begin
            wordCnt_q <= wordCnt_d;
            if (lastWord) begin
              state_q <= IDLE;
              mmReq_q <= 1'b0;
            end else begin
              mmAddr_q <= blockAddr(reqTag, reqIndex, wordCnt_d);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          mmReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hit       = hitNow;
  assign bus.mem_rdata = lineData[reqWord];
  assign bus.mm_req    = mmReq_q;
  assign bus.mm_we     = mmWe_q;
  assign bus.mm_addr   = mmAddr_q;
  assign bus.mm_wdata  = mmWdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;

  // Statistics: one count per hit cycle and one per miss leaving IDLE, both free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (hitNow) begin
        hitCount_q <= hitCount_q + 32'd1;
      end
      if (missStart) begin
        missCount_q <= missCount_q + 32'd1;
      end
    end
  end

  assign bus.hit_count  = hitCount_q;
  assign bus.miss_count = missCount_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized self-checking bench for dcache_controller.
// The reference is a flat architectural memory plus a set-level cache model;
// the bench also acts as main memory with a per-word ack latency.
module tb_dcache_controller;
  import dcache_pkg::*;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dcache_if bus();

  dcache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] mainMem [logic [31:0]];
  logic [31:0] arch    [logic [31:0]];

  bit          mValid [64];
  bit          mDirty [64];
  logic [21:0] mTag   [64];
  logic [31:0] mData  [64][4];
  int unsigned expHits;
  int unsigned expMisses;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (mainMem.exists(w)) return mainMem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] archRead(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (arch.exists(w)) return arch[w];
    return memRead(w);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    arch.delete();
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic checkCounters();
`ifdef DCACHE_STATS_EN
    checkOutput("hitCount", bus.hit_count, expHits);
    checkOutput("missCount", bus.miss_count, expMisses);
`else
    checkOutput("hitCount", bus.hit_count, 32'd0);
    checkOutput("missCount", bus.miss_count, 32'd0);
`endif
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.mem_req = 1'b0;
    bus.mm_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("resetHit", bus.hit, 1'b0);
    checkOutput("resetMmReq", bus.mm_req, 1'b0);
    checkCounters();
  endtask

  // One core access held until hit, with the bench serving main-memory words.
  task automatic applyStimulus(input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat);
    txn_t        expQ [$];
    txn_t        t;
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [1:0]  w;
    bit          expHit;
    bit          done;
    int          expCycles;
    int          c;
    int          waitCnt;

    idx    = addr[9:4];
    tg     = addr[31:10];
    w      = addr[3:2];
    expHit = mValid[idx] && (mTag[idx] == tg);
    expCycles = 1;
    if (!expHit) begin
      expCycles = 2 + 4 * lat;
      if (mValid[idx] && mDirty[idx]) begin
        expCycles += 4 * lat;
        for (int k = 0; k < 4; k++) begin
          t.we = 1'b1; t.addr = {mTag[idx], idx, 2'(k), 2'b00}; t.data = mData[idx][k];
          expQ.push_back(t);
        end
      end
      for (int k = 0; k < 4; k++) begin
        t.we = 1'b0; t.addr = {tg, idx, 2'(k), 2'b00}; t.data = '0;
        expQ.push_back(t);
      end
    end

    bus.mem_req      = 1'b1;
    bus.mem_write_en = we;
    bus.mem_addr     = addr;
    bus.mem_wdata    = wdata;
    done    = 1'b0;
    c       = 0;
    waitCnt = 0;
    while (!done && c < 200) begin
      #1;
      if (c == 0) begin
        checkOutput("firstCycleHit", bus.hit, expHit);
        checkOutput("firstCycleMmReq", bus.mm_req, 1'b0);
      end
      if (bus.hit) begin
        checkOutput("hitCycle", c, expCycles - 1);
        checkOutput("burstsDone", expQ.size(), 0);
        checkOutput("mmReqDuringHit", bus.mm_req, 1'b0);
        if (!we) checkOutput("loadData", bus.mem_rdata, archRead(addr));
        done = 1'b1;
      end else if (bus.mm_req) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedMmReq", bus.mm_req, 1'b0);
          bus.mm_ack   = 1'b1;
          bus.mm_rdata = memRead(bus.mm_addr);
        end else begin
          checkOutput("mmWe", bus.mm_we, expQ[0].we);
          checkOutput("mmAddr", bus.mm_addr, expQ[0].addr);
          if (expQ[0].we) checkOutput("mmWdata", bus.mm_wdata, expQ[0].data);
          if (waitCnt == lat - 1) begin
            bus.mm_ack = 1'b1;
            if (expQ[0].we) mainMem[bus.mm_addr & ~32'd3] = bus.mm_wdata;
            else bus.mm_rdata = memRead(bus.mm_addr);
            void'(expQ.pop_front());
            waitCnt = 0;
          end else begin
            waitCnt++;
          end
        end
      end
      @(negedge clk);
      bus.mm_ack = 1'b0;
      c++;
    end
    if (!done) checkOutput("accessTimeout", c, expCycles - 1);
    bus.mem_req = 1'b0;

    if (done) begin
      if (!expHit) begin
        for (int k = 0; k < 4; k++) mData[idx][k] = memRead({tg, idx, 2'(k), 2'b00});
        mValid[idx] = 1'b1;
        mDirty[idx] = 1'b0;
        mTag[idx]   = tg;
        expMisses++;
      end
      expHits++;
      if (we) begin
        mData[idx][w] = wdata;
        mDirty[idx]   = 1'b1;
        arch[addr & ~32'd3] = wdata;
      end
    end
    #1;
    checkCounters();
  endtask

  // Idle cycles with stray mm_ack pulses that the cache must ignore.
  task automatic idleCycles(input int n);
    bus.mem_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mm_ack   = 1'($urandom_range(0, 1));
      bus.mm_rdata = $urandom;
      bus.mem_addr = $urandom;
      #1;
      checkOutput("idleHit", bus.hit, 1'b0);
      checkOutput("idleMmReq", bus.mm_req, 1'b0);
      @(negedge clk);
    end
    bus.mm_ack = 1'b0;
  endtask

  // Starts a refill, lets two words arrive, then resets mid-burst.
  task automatic resetDuringRefill(input logic [31:0] addr);
    int acks;
    int waitCnt;
    int c;
    bus.mem_req      = 1'b1;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = addr;
    acks    = 0;
    waitCnt = 0;
    c       = 0;
    while (acks < 2 && c < 100) begin
      #1;
      if (bus.mm_req) begin
        if (waitCnt == 2) begin
          bus.mm_ack   = 1'b1;
          bus.mm_rdata = memRead(bus.mm_addr);
          acks++;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end
      @(negedge clk);
      bus.mm_ack = 1'b0;
      c++;
    end
    checkOutput("refillAcksSeen", acks, 2);
    #1;
    checkOutput("stillRefilling", bus.mm_req, 1'b1);
    rst = 1'b1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mmReqAfterReset", bus.mm_req, 1'b0);
    checkOutput("hitAfterReset", bus.hit, 1'b0);
    rst = 1'b0;
    modelReset();
    checkCounters();
  endtask

  // Directed scenarios first, then randomized traffic over a few colliding sets.
  initial begin
    rst              = 1'b1;
    bus.mem_req      = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mm_rdata     = '0;
    bus.mm_ack       = 1'b0;
    @(negedge clk);
    doReset();

    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 3);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 3);
    applyStimulus(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 3);
    applyStimulus(1'b0, 32'h0000_0444, 32'h0, 3);
    checkOutput("wbWord44", memRead(32'h44), 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 2);

    resetDuringRefill(32'h0000_0880);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1);

    applyStimulus(1'b1, 32'h0000_0800, 32'h1234_5678, 2);
    applyStimulus(1'b0, 32'h0000_0C00, 32'h0, 2);
    checkOutput("wbWord800", memRead(32'h800), 32'h1234_5678);
    idleCycles(5);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) idleCycles($urandom_range(1, 3));
      a = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
